// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-Stream packet round-robin arbiter.
package axis_arb_pkg;

   // Arbiter FSM: IDLE waits for an eligible requester, LOCKED holds a grant.
   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   // Modulo-n increment of a channel index; n need not be a power of two.
   function automatic int rr_next_idx(input int ptr, input int n);
      return (ptr >= n - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set bit of req, scanning from ptr+1
// upward with wrap-around. Implemented as a double-width rotate followed by a
// lowest-bit priority encoder on the rotated vector.
module rr_priority_picker
   import axis_arb_pkg::*;
#(
   parameter int N = 5,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic         any,
   output logic [W-1:0] idx,
   output logic [N-1:0] onehot
);

   logic [2*N-1:0] dbl;
   logic [N-1:0]   rot;
   int             start;
   int             sum;

   // Rotate so that channel ptr+1 lands in bit 0, then take the lowest set bit.
   always_comb begin
      start = rr_next_idx(int'(ptr), N);
      dbl   = {req, req} >> start;
      rot   = dbl[N-1:0];
      any   = |rot;
      idx   = '0;
      sum   = 0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) begin
            sum = start + k;
            if (sum >= N) begin
               sum = sum - N;
            end
            idx = W'(sum);
         end
      end
   end

   // One-hot form of the picked index; all-zero when nothing is eligible.
   for (genvar gi = 0; gi < N; gi++) begin : g_onehot
      assign onehot[gi] = any && (idx == W'(gi));
   end

endmodule

// File: rtl/axis_rr_packet_arbiter.sv
// Packet-level round-robin arbiter driving en/ctrl of an N:1 AXI-Stream mux.
// A grant is held until the accepted TLAST beat and/or a burst limit, then
// re-arbitrated in the same cycle so back-to-back packets see no bubble.
module axis_rr_packet_arbiter
   import axis_arb_pkg::*;
#(
   parameter int CHANNEL_NUMBER       = 5,
   parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
   parameter bit LOCK_ON_TLAST        = 1'b1,
   parameter int MAX_BURST            = 0
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic [CHANNEL_NUMBER-1:0]       req_i,
   input  logic [CHANNEL_NUMBER-1:0]       mask_i,
   input  logic                            hs_i,
   input  logic                            last_i,
   output logic                            en_o,
   output logic [CHANNEL_NUMBER_WIDTH-1:0] ctrl_o,
   output logic [CHANNEL_NUMBER-1:0]       grant_o
);

   localparam int BEAT_W = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

   // A grant that can never be released would lock the mux forever.
   if (!LOCK_ON_TLAST && MAX_BURST == 0) begin : g_bad_cfg
      $error("axis_rr_packet_arbiter: LOCK_ON_TLAST=0 requires MAX_BURST>0");
   end

   arb_state_e                      state_reg, state_next;
   logic                            en_reg, en_next;
   logic [CHANNEL_NUMBER_WIDTH-1:0] ctrl_reg, ctrl_next;
   logic [CHANNEL_NUMBER-1:0]       grant_reg, grant_next;
   logic [CHANNEL_NUMBER_WIDTH-1:0] rr_ptr_reg, rr_ptr_next;
   logic [BEAT_W-1:0]               beat_cnt_reg, beat_cnt_next;

   logic [CHANNEL_NUMBER-1:0]       elig;
   logic [CHANNEL_NUMBER_WIDTH-1:0] pick_ptr;
   logic                            pick_any;
   logic [CHANNEL_NUMBER_WIDTH-1:0] pick_idx;
   logic [CHANNEL_NUMBER-1:0]       pick_onehot;
   logic                            burst_hit;
   logic                            tlast_hit;
   logic                            rel;

   assign elig = req_i & mask_i;

   // While locked the only pick that matters is the release re-pick, which
   // starts after the finishing channel; the finisher is thereby lowest priority.
   assign pick_ptr = (state_reg == LOCKED) ? ctrl_reg : rr_ptr_reg;

   rr_priority_picker #(
      .N (CHANNEL_NUMBER),
      .W (CHANNEL_NUMBER_WIDTH)
   ) u_picker (
      .req    (elig),
      .ptr    (pick_ptr),
      .any    (pick_any),
      .idx    (pick_idx),
      .onehot (pick_onehot)
   );

   if (MAX_BURST > 0) begin : g_burst
      assign burst_hit = (beat_cnt_reg == BEAT_W'(MAX_BURST - 1));
   end else begin : g_no_burst
      assign burst_hit = 1'b0;
   end

   assign tlast_hit = LOCK_ON_TLAST && last_i;
   assign rel       = (state_reg == LOCKED) && hs_i && (tlast_hit || burst_hit);

   // State, pointer, counter and registered mux controls.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_reg    <= IDLE;
         en_reg       <= 1'b0;
         ctrl_reg     <= '0;
         grant_reg    <= '0;
         rr_ptr_reg   <= CHANNEL_NUMBER_WIDTH'(CHANNEL_NUMBER - 1);
         beat_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         en_reg       <= en_next;
         ctrl_reg     <= ctrl_next;
         grant_reg    <= grant_next;
         rr_ptr_reg   <= rr_ptr_next;
         beat_cnt_reg <= beat_cnt_next;
      end
   end

   // Next-state logic: grant from IDLE, hold or release-and-regrant in LOCKED.
   always_comb begin
      state_next    = state_reg;
      en_next       = en_reg;
      ctrl_next     = ctrl_reg;
      grant_next    = grant_reg;
      rr_ptr_next   = rr_ptr_reg;
      beat_cnt_next = beat_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (pick_any) begin
               state_next    = LOCKED;
               en_next       = 1'b1;
               ctrl_next     = pick_idx;
               grant_next    = pick_onehot;
               beat_cnt_next = '0;
            end
         end
         LOCKED: begin
            if (rel) begin
               rr_ptr_next   = ctrl_reg;
               beat_cnt_next = '0;
               if (pick_any) begin
                  ctrl_next  = pick_idx;
                  grant_next = pick_onehot;
               end else begin
                  state_next = IDLE;
                  en_next    = 1'b0;
                  grant_next = '0;
               end
            end else if (hs_i && (beat_cnt_reg != '1)) begin
               beat_cnt_next = beat_cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            en_next    = 1'b0;
            grant_next = '0;
         end
      endcase
   end

   assign en_o    = en_reg;
   assign ctrl_o  = ctrl_reg;
   assign grant_o = grant_reg;

endmodule
